// File: rtl/fifo_ctrl_pkg.sv
// Shared lab constants and types for the queue controller and its 32x16 distributed RAM.
package fifo_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [ADDR_W:0]   cnt_t;

  // Operation selected for the current cycle; exactly one per cycle.
  typedef enum logic [2:0] {
    OP_IDLE,       // no access, head word previewed on the read port
    OP_PUSH,       // write din at wr_ptr
    OP_POP,        // read head into dout
    OP_POP_DEFER,  // read head now, park the simultaneous push for next cycle
    OP_PEND_WR     // write the parked push word
  } op_e;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Queue-side request/response bundle between a producer/consumer and fifo_ctrl.
interface fifo_ctrl_if;
  import fifo_ctrl_pkg::*;

  logic  push;
  logic  pop;
  word_t din;
  word_t dout;
  logic  full;
  logic  empty;
  cnt_t  count;

  modport master (output push, pop, din, input dout, full, empty, count);
  modport slave  (input push, pop, din, output dout, full, empty, count);

endinterface

// File: rtl/fifo_ctrl_edge_detect.sv
// Rising-edge detector; previous value resets to 1 so a level held through reset gives no pulse.
module fifo_ctrl_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_pulse
);

  logic r_prev;

  // Register the previous input level.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (i_rst) r_prev <= 1'b1;
    else       r_prev <= i_sig;
  end

  assign o_pulse = i_sig & ~r_prev;

endmodule

// File: rtl/fifo_ctrl.sv
// Circular-buffer controller driving an external 32x16 RAM (async read).
module fifo_ctrl
  import fifo_ctrl_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  fifo_ctrl_if.slave      bus,
  output ptr_t            o_mem_a,
  output word_t           o_mem_wd,
  output logic            o_mem_we,
  input  word_t           i_mem_rd
);

  logic  w_push_e, w_pop_e;
  logic  w_full, w_empty;
  op_e   w_op;

  ptr_t  r_wr_ptr, r_rd_ptr;
  cnt_t  r_count;
  logic  r_pend;
  word_t r_pend_d;
  word_t r_dout;

  fifo_ctrl_edge_detect u_push_edge (
    .i_clk(i_clk), .i_rst(i_rst), .i_sig(bus.push), .o_pulse(w_push_e)
  );

  fifo_ctrl_edge_detect u_pop_edge (
    .i_clk(i_clk), .i_rst(i_rst), .i_sig(bus.pop), .o_pulse(w_pop_e)
  );

  assign w_full  = (r_count == cnt_t'(DEPTH));
  assign w_empty = (r_count == '0);

  // Pick this cycle's operation: parked push first, then pop, then push.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_op unassigned (no latch).
    w_op = OP_IDLE;
    if (i_rst)                     w_op = OP_IDLE;
    else if (r_pend)               w_op = OP_PEND_WR;
    else if (w_pop_e && !w_empty)  w_op = w_push_e ? OP_POP_DEFER : OP_POP;
    else if (w_push_e && !w_full)  w_op = OP_PUSH;
  end

  // Drive the RAM port; idle and pop cycles address the head word.
  always_comb begin
    o_mem_a  = r_rd_ptr;
    o_mem_wd = bus.din;
    o_mem_we = 1'b0;
    case (w_op)
      OP_PUSH: begin
        o_mem_a  = r_wr_ptr;
        o_mem_we = 1'b1;
      end
      OP_PEND_WR: begin
        o_mem_a  = r_wr_ptr;
        o_mem_wd = r_pend_d;
        o_mem_we = 1'b1;
      end
      default: ;
    endcase
  end

  // Advance pointers, occupancy, the parked push and the dequeued word.
  always_ff @(posedge i_clk) begin
    // NOTE: queue storage is the external RAM and is not cleared; resetting the pointers
    // and count is enough to make stale words unreachable.
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_pend   <= 1'b0;
      r_pend_d <= '0;
      r_dout   <= '0;
    end else begin
      case (w_op)
        OP_PUSH: begin
          r_wr_ptr <= r_wr_ptr + ptr_t'(1);
          r_count  <= r_count + cnt_t'(1);
        end
        OP_PEND_WR: begin
          r_wr_ptr <= r_wr_ptr + ptr_t'(1);
          r_count  <= r_count + cnt_t'(1);
          r_pend   <= 1'b0;
        end
        OP_POP: begin
          r_rd_ptr <= r_rd_ptr + ptr_t'(1);
          r_count  <= r_count - cnt_t'(1);
          r_dout   <= i_mem_rd;
        end
        OP_POP_DEFER: begin
          r_rd_ptr <= r_rd_ptr + ptr_t'(1);
          r_count  <= r_count - cnt_t'(1);
          r_dout   <= i_mem_rd;
          r_pend   <= 1'b1;
          r_pend_d <= bus.din;
        end
        default: ;
      endcase
    end
  end

  assign bus.dout  = r_dout;
  assign bus.full  = w_full;
  assign bus.empty = w_empty;
  assign bus.count = r_count;

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Queue controller sitting directly upstream of the lab2 32×16 distributed-RAM instance: it turns push/pop requests into that memory's address/write-data/write-enable and captures its asynchronous read data as the dequeued word. Circular-buffer pointers, an occupancy counter, full/empty flags and push/pop rising-edge detection live here; the memory itself stays outside.

## Interface
- `DATA_W`, 16: word width; equals the memory data width.
- `ADDR_W`, 5: memory address width; depth = 2^ADDR_W = 32.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `push`  in  1  enqueue request, level; acted on at rising edge only.
- `pop`  in  1  dequeue request, level; acted on at rising edge only.
- `din`  in  DATA_W  word to enqueue, sampled in the accepting cycle.
- `dout`  out  DATA_W  last dequeued word, registered.
- `full`  out  1  count == 32.
- `empty`  out  1  count == 0.
- `count`  out  ADDR_W+1  occupancy 0..32.
- `mem_a`  out  ADDR_W  memory address.
- `mem_wd`  out  DATA_W  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_rd`  in  DATA_W  memory combinational read data at `mem_a`.

## Operation
- Edge detect: `push_e = push & ~push_q`, `pop_e = pop & ~pop_q`; `push_q`/`pop_q` register the inputs each cycle.
- State: `wr_ptr`, `rd_ptr` (ADDR_W bits, wrap 31→0 naturally), `count`, `pend` (1 bit), `pend_d` (DATA_W).
- Accepted pop (`pop_e & ~empty`): `mem_a = rd_ptr`; `dout <= mem_rd`; `rd_ptr++`.
- Accepted push (`push_e & ~full`, no pop edge): `mem_a = wr_ptr`, `mem_wd = din`, `mem_we = 1`; `wr_ptr++`.
- Simultaneous `push_e & pop_e`, not empty: pop served this cycle; `pend <= 1`, `pend_d <= din`. Next cycle: write `pend_d` at `wr_ptr`, `wr_ptr++`, `pend <= 0`. Push is never lost, even if full at the edge (pop frees a slot).
- Simultaneous edges while empty: pop rejected, push performed immediately.
- Push while full or pop while empty (single edge): ignored; no state change, `mem_we = 0`, `dout` holds.
- `count` = +1 on each write, −1 on each accepted pop; never exceeds 32 or underflows.
- Idle (no op): `mem_a = rd_ptr` so `mem_rd` previews the head word; `mem_we = 0`; `mem_wd = din`.

## Timing
- Reset values: `wr_ptr`, `rd_ptr`, `count`, `pend`, `pend_d`, `dout` = 0; `empty` = 1, `full` = 0; `mem_we` = 0; `mem_a` = 0.
- `push_q`, `pop_q` reset to 1: a request held high through reset release produces no edge.
- `mem_a`, `mem_wd`, `mem_we`: combinational from current state and edges; write completes at the same clock edge as the accept.
- `dout` updates one edge after the pop edge is sampled (latency 1). `count`/`full`/`empty` are derived from the registered count, valid the cycle after the op.
- Pending push occupies exactly one extra cycle; no new edge can arrive then (each edge needs an intervening low cycle), so no further arbitration is needed.
- Reset mid-operation (including with `pend = 1`): everything returns to reset values; the pending word is discarded; memory contents are not cleared but are unreachable.

## Structure
- `DATA_W`, `ADDR_W`, and derived `DEPTH` go in the shared lab constants header, alongside the memory generator's width/depth, so both stay in step.
- One sub-module: `edge_detect` (input, clk, rst, registered-previous, pulse out, reset value 1), instantiated for `push` and `pop`.
- Memory instance lives in the enclosing top; `fifo_ctrl` connects `mem_*` to its `a`/`d`/`we`/`spo`.

## Test plan
- Reset with `push` held high, release -> no write, `count` = 0, `empty` = 1, `dout` = 0.
- Push 0x0011, 0x0022, 0x0033 (one-cycle pulses with low gaps) then pop ×3 -> `dout` 0x0011, 0x0022, 0x0033 in order; `empty` = 1 after the last.
- Push 32 words 0x1000+i -> `full` = 1, `count` = 32; 33rd push 0xDEAD -> `mem_we` stays 0; pop 32 -> data 0x1000..0x101F, pointers wrapped to 0.
- With 2 words queued (0xAAAA, 0xBBBB), push 0xCCCC and pop on the same edge -> `dout` = 0xAAAA, next cycle `mem_we` = 1 writing 0xCCCC, `count` stays 2; subsequent pops give 0xBBBB, 0xCCCC.
- Empty, simultaneous push 0x0055 and pop -> pop ignored, 0x0055 written at once, `count` = 1, `dout` unchanged; same with full -> pop served, push written next cycle, `count` stays 32.
- Assert `rst` in the pending-push cycle -> all outputs at reset values next cycle, `mem_we` = 0, subsequent pop while empty ignored.
